// File: rtl/act_mem_pkg.sv
// Shared types and helpers for the activation-memory write loader.
package act_mem_pkg;

  localparam int unsigned ACT_IDX_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when (y,x) lies in the zero-padded border of a dim x dim map
  function automatic logic is_border(input logic [ACT_IDX_W-1:0] y,
                                     input logic [ACT_IDX_W-1:0] x,
                                     input int unsigned          dim,
                                     input int unsigned          pad);
    return (32'(y) < pad) || (32'(y) >= dim - pad) ||
           (32'(x) < pad) || (32'(x) >= dim - pad);
  endfunction

endpackage

// File: rtl/act_mem_loader_if.sv
// Activation stream in, memory write command out.
interface act_mem_loader_if
  import act_mem_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 64
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_SIZE-1:0] in_data;
  logic                 mem_write;
  logic [ACT_IDX_W-1:0] mem_index_entry;
  logic [ACT_IDX_W-1:0] mem_index_y;
  logic [ACT_IDX_W-1:0] mem_index_x;
  logic [DATA_SIZE-1:0] mem_in_data;

  // Loader side
  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_write, mem_index_entry, mem_index_y, mem_index_x, mem_in_data
  );

  // Producer / memory side
  modport master (
    output in_valid, in_data,
    input  in_ready, mem_write, mem_index_entry, mem_index_y, mem_index_x, mem_in_data
  );

endinterface

// File: rtl/act_idx_counter.sv
// Nested entry/row/column position counter, x fastest.
module act_idx_counter
  import act_mem_pkg::*;
#(
  parameter int unsigned ENTRY_NUM = 16,
  parameter int unsigned DIM       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clear,
  input  logic                 i_advance,
  output logic [ACT_IDX_W-1:0] o_e,
  output logic [ACT_IDX_W-1:0] o_y,
  output logic [ACT_IDX_W-1:0] o_x,
  output logic                 o_last_c
);

  localparam logic [ACT_IDX_W-1:0] L_E_MAX = ACT_IDX_W'(ENTRY_NUM - 1);
  localparam logic [ACT_IDX_W-1:0] L_D_MAX = ACT_IDX_W'(DIM - 1);
  localparam logic [ACT_IDX_W-1:0] L_ONE   = ACT_IDX_W'(1);

  logic [ACT_IDX_W-1:0] r_e, r_y, r_x;
  logic                 w_x_wrap, w_y_wrap;

  assign w_x_wrap = (r_x == L_D_MAX);
  assign w_y_wrap = (r_y == L_D_MAX);

  // Advance the position; each wrap carries into the next slower counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e <= '0;
      r_y <= '0;
      r_x <= '0;
    end else if (i_clear) begin
      r_e <= '0;
      r_y <= '0;
      r_x <= '0;
    end else if (i_advance) begin
      r_x <= w_x_wrap ? '0 : r_x + L_ONE;
      if (w_x_wrap) begin
        r_y <= w_y_wrap ? '0 : r_y + L_ONE;
        if (w_y_wrap) begin
          r_e <= (r_e == L_E_MAX) ? '0 : r_e + L_ONE;
        end
      end
    end
  end

  assign o_e      = r_e;
  assign o_y      = r_y;
  assign o_x      = r_x;
  assign o_last_c = (r_e == L_E_MAX) && w_y_wrap && w_x_wrap;

endmodule

// File: rtl/act_mem_loader.sv
// Write-side sequencer for the activation memory: walks one frame, inserts
// border zeros on its own and forwards interior words from the input stream.
module act_mem_loader
  import act_mem_pkg::*;
#(
  parameter int unsigned ENTRY_NUM = 16,
  parameter int unsigned DIM       = 8,
  parameter int unsigned PAD       = 1,
  parameter int unsigned DATA_SIZE = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  act_mem_loader_if.slave  bus
);

  state_t               r_state, w_next;
  logic                 r_flush;
  logic                 w_issue, w_ready, w_border, w_last;
  logic [ACT_IDX_W-1:0] w_e, w_y, w_x;

  logic                 r_mem_write;
  logic [ACT_IDX_W-1:0] r_idx_e, r_idx_y, r_idx_x;
  logic [DATA_SIZE-1:0] r_data;
  logic                 r_busy, r_done;

  act_idx_counter #(
    .ENTRY_NUM (ENTRY_NUM),
    .DIM       (DIM)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (r_state != LOAD),
    .i_advance (w_issue),
    .o_e       (w_e),
    .o_y       (w_y),
    .o_x       (w_x),
    .o_last_c  (w_last)
  );

  assign w_border = is_border(w_y, w_x, DIM, PAD);

  // Next state and per-cycle issue decision; r_flush marks the cycle in which
  // the final write is on the memory port so done lands one cycle after it
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    w_ready = 1'b0;
    unique case (r_state)
      IDLE: if (start) w_next = LOAD;
      LOAD: begin
        if (r_flush) begin
          w_next = DONE;
        end else begin
          w_ready = !w_border;
          w_issue = w_border || bus.in_valid;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register and end-of-frame marker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_next;
      r_flush <= w_issue && w_last;
    end
  end

  // Registered write command; index/data hold while no write is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_write <= 1'b0;
      r_idx_e     <= '0;
      r_idx_y     <= '0;
      r_idx_x     <= '0;
      r_data      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_mem_write <= w_issue;
      r_busy      <= (w_next == LOAD);
      r_done      <= (w_next == DONE);
      if (w_issue) begin
        r_idx_e <= w_e;
        r_idx_y <= w_y;
        r_idx_x <= w_x;
        r_data  <= w_border ? '0 : bus.in_data;
      end
    end
  end

  assign bus.in_ready        = w_ready;
  assign bus.mem_write       = r_mem_write;
  assign bus.mem_index_entry = r_idx_e;
  assign bus.mem_index_y     = r_idx_y;
  assign bus.mem_index_x     = r_idx_x;
  assign bus.mem_in_data     = r_data;
  assign busy                = r_busy;
  assign done                = r_done;

endmodule

// File: tb/tb_act_mem_loader.sv
// Scoreboard bench for act_mem_loader: one padded instance (2x4x4, PAD=1)
// and one unpadded instance (1x3x3, PAD=0).
module tb_act_mem_loader;

  typedef struct {
    int          e;
    int          y;
    int          x;
    logic [63:0] d;
    bit          border;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic a_start = 1'b0, b_start = 1'b0;
  logic a_busy, a_done, b_busy, b_done;

  act_mem_loader_if #(.DATA_SIZE(64)) a_if ();
  act_mem_loader_if #(.DATA_SIZE(64)) b_if ();

  act_mem_loader #(.ENTRY_NUM(2), .DIM(4), .PAD(1), .DATA_SIZE(64)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done), .bus(a_if)
  );

  act_mem_loader #(.ENTRY_NUM(1), .DIM(3), .PAD(0), .DATA_SIZE(64)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done), .bus(b_if)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, cyc = 0;

  wr_t         a_exp [$], b_exp [$];
  logic [63:0] a_words [$], b_words [$];
  logic [63:0] a_mem [int];
  int a_frame_wr = 0, a_first_wr = 0, a_last_wr = 0, a_done_cnt = 0, a_done_cyc = 0;
  int b_frame_wr = 0, b_first_wr = 0, b_last_wr = 0, b_done_cnt = 0, b_done_cyc = 0;
  bit a_toggle = 1'b0, a_phase = 1'b0;
  wr_t  a_w, b_w;
  logic a_exp_rdy, b_exp_rdy;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic bit on_border(input int y, input int x, input int dim, input int pad);
    return (y < pad) || (y >= dim - pad) || (x < pad) || (x >= dim - pad);
  endfunction

  function automatic logic [63:0] gold(input int e, input int y, input int x,
                                       input int dim, input int pad, input int first);
    int inner;
    inner = dim - 2 * pad;
    if (on_border(y, x, dim, pad)) return 64'd0;
    return 64'(first + e * inner * inner + (y - pad) * inner + (x - pad));
  endfunction

  // Push the expected write sequence and the interior word stream of one frame
  task automatic push_frame(input bit sel, input int ne, input int dim, input int pad, input int first);
    wr_t w;
    int  inner;
    inner = dim - 2 * pad;
    for (int e = 0; e < ne; e++)
      for (int y = 0; y < dim; y++)
        for (int x = 0; x < dim; x++) begin
          w.e = e; w.y = y; w.x = x;
          w.border = on_border(y, x, dim, pad);
          w.d = gold(e, y, x, dim, pad, first);
          if (sel) b_exp.push_back(w); else a_exp.push_back(w);
        end
    for (int i = 0; i < ne * inner * inner; i++) begin
      if (sel) b_words.push_back(64'(first + i)); else a_words.push_back(64'(first + i));
    end
  endtask

  // Consume words on handshake
  always @(posedge clk) begin
    cyc++;
    if (a_if.in_valid && a_if.in_ready && a_words.size() != 0) void'(a_words.pop_front());
    if (b_if.in_valid && b_if.in_ready && b_words.size() != 0) void'(b_words.pop_front());
  end

  // Present the next word away from the clock edge
  always @(negedge clk) begin
    a_phase = !a_phase;
    a_if.in_valid = (a_words.size() != 0) && (!a_toggle || a_phase);
    a_if.in_data  = (a_words.size() != 0) ? a_words[0] : 64'd0;
    b_if.in_valid = (b_words.size() != 0);
    b_if.in_data  = (b_words.size() != 0) ? b_words[0] : 64'd0;
  end

  // Monitor A: scoreboard writes, count done, check in_ready against the next position
  always @(negedge clk) begin
    if (a_if.mem_write === 1'b1) begin
      if (a_frame_wr == 0) a_first_wr = cyc;
      a_frame_wr++;
      a_last_wr = cyc;
      a_mem[int'(a_if.mem_index_entry) * 16 + int'(a_if.mem_index_y) * 4 + int'(a_if.mem_index_x)] = a_if.mem_in_data;
      if (a_exp.size() == 0) begin
        chk("a_extra_write", 64'd1, 64'd0);
      end else begin
        a_w = a_exp.pop_front();
        chk("a_index", {16'd0, a_if.mem_index_entry, a_if.mem_index_y, a_if.mem_index_x},
            {16'd0, 16'(a_w.e), 16'(a_w.y), 16'(a_w.x)});
        chk("a_data", a_if.mem_in_data, a_w.d);
      end
    end
    if (a_done === 1'b1) begin
      a_done_cnt++;
      a_done_cyc = cyc;
    end
    a_exp_rdy = (a_busy === 1'b1 && a_exp.size() != 0) ? !a_exp[0].border : 1'b0;
    chk("a_in_ready", 64'(a_if.in_ready), 64'(a_exp_rdy));
  end

  // Monitor B
  always @(negedge clk) begin
    if (b_if.mem_write === 1'b1) begin
      if (b_frame_wr == 0) b_first_wr = cyc;
      b_frame_wr++;
      b_last_wr = cyc;
      if (b_exp.size() == 0) begin
        chk("b_extra_write", 64'd1, 64'd0);
      end else begin
        b_w = b_exp.pop_front();
        chk("b_index", {16'd0, b_if.mem_index_entry, b_if.mem_index_y, b_if.mem_index_x},
            {16'd0, 16'(b_w.e), 16'(b_w.y), 16'(b_w.x)});
        chk("b_data", b_if.mem_in_data, b_w.d);
      end
    end
    if (b_done === 1'b1) begin
      b_done_cnt++;
      b_done_cyc = cyc;
    end
    b_exp_rdy = (b_busy === 1'b1 && b_exp.size() != 0) ? !b_exp[0].border : 1'b0;
    chk("b_in_ready", 64'(b_if.in_ready), 64'(b_exp_rdy));
  end

  task automatic pulse_start(input bit sel);
    @(posedge clk); #1;
    if (sel) b_start = 1'b1; else a_start = 1'b1;
    @(posedge clk); #1;
    if (sel) b_start = 1'b0; else a_start = 1'b0;
    chk(sel ? "b_busy_after_start" : "a_busy_after_start", 64'(sel ? b_busy : a_busy), 64'd1);
  endtask

  task automatic wait_done(input bit sel, input int limit);
    int base;
    int t;
    base = sel ? b_done_cnt : a_done_cnt;
    t = 0;
    while (((sel ? b_done_cnt : a_done_cnt) == base) && t < limit) begin
      @(posedge clk);
      t++;
    end
    chk(sel ? "b_done_seen" : "a_done_seen", 64'((sel ? b_done_cnt : a_done_cnt) != base), 64'd1);
  endtask

  task automatic wait_wr_a(input int n, input int limit);
    int t;
    t = 0;
    while (a_frame_wr < n && t < limit) begin
      @(posedge clk);
      t++;
    end
    chk("a_write_count_reached", 64'(a_frame_wr >= n), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    chk("rst_a_mem_write", 64'(a_if.mem_write), 64'd0);
    chk("rst_a_busy", 64'(a_busy), 64'd0);
    chk("rst_a_done", 64'(a_done), 64'd0);
    chk("rst_a_in_ready", 64'(a_if.in_ready), 64'd0);
    chk("rst_a_index", {16'd0, a_if.mem_index_entry, a_if.mem_index_y, a_if.mem_index_x}, 64'd0);
    chk("rst_a_data", a_if.mem_in_data, 64'd0);
    chk("rst_b_busy", 64'(b_busy), 64'd0);
    chk("rst_b_mem_write", 64'(b_if.mem_write), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Frame with in_valid held high
    push_frame(1'b0, 2, 4, 1, 1);
    a_frame_wr = 0; base = a_done_cnt;
    pulse_start(1'b0);
    wait_done(1'b0, 200);
    repeat (2) @(posedge clk);
    chk("t1_writes", 64'(a_frame_wr), 64'd32);
    chk("t1_consecutive", 64'(a_last_wr - a_first_wr), 64'd31);
    chk("t1_done_latency", 64'(a_done_cyc - a_last_wr), 64'd1);
    chk("t1_done_pulses", 64'(a_done_cnt - base), 64'd1);
    chk("t1_exp_left", 64'(a_exp.size()), 64'd0);
    chk("t1_words_left", 64'(a_words.size()), 64'd0);
    chk("t1_busy_low", 64'(a_busy), 64'd0);
    for (int e = 0; e < 2; e++)
      for (int y = 0; y < 4; y++)
        for (int x = 0; x < 4; x++)
          chk("t6_padded_map", a_mem.exists(e * 16 + y * 4 + x) ? a_mem[e * 16 + y * 4 + x] : 64'hDEAD,
              gold(e, y, x, 4, 1, 1));

    // in_valid toggling every cycle
    a_toggle = 1'b1;
    push_frame(1'b0, 2, 4, 1, 9);
    a_frame_wr = 0; base = a_done_cnt;
    pulse_start(1'b0);
    wait_done(1'b0, 400);
    repeat (2) @(posedge clk);
    chk("t2_writes", 64'(a_frame_wr), 64'd32);
    chk("t2_exp_left", 64'(a_exp.size()), 64'd0);
    chk("t2_words_left", 64'(a_words.size()), 64'd0);
    chk("t2_done_pulses", 64'(a_done_cnt - base), 64'd1);
    a_toggle = 1'b0;

    // Unpadded instance
    push_frame(1'b1, 1, 3, 0, 10);
    b_frame_wr = 0; base = b_done_cnt;
    pulse_start(1'b1);
    wait_done(1'b1, 100);
    repeat (2) @(posedge clk);
    chk("t3_writes", 64'(b_frame_wr), 64'd9);
    chk("t3_consecutive", 64'(b_last_wr - b_first_wr), 64'd8);
    chk("t3_done_latency", 64'(b_done_cyc - b_last_wr), 64'd1);
    chk("t3_exp_left", 64'(b_exp.size()), 64'd0);
    chk("t3_done_pulses", 64'(b_done_cnt - base), 64'd1);

    // start during LOAD and during DONE is ignored
    push_frame(1'b0, 2, 4, 1, 21);
    a_frame_wr = 0; base = a_done_cnt;
    pulse_start(1'b0);
    wait_wr_a(10, 100);
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    chk("t4_busy_mid", 64'(a_busy), 64'd1);
    wait_wr_a(32, 200);
    #1;
    chk("t4_in_done", 64'(a_done), 64'd1);
    chk("t4_busy_in_done", 64'(a_busy), 64'd0);
    a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("t4_idle_after", 64'(a_busy), 64'd0);
    chk("t4_writes", 64'(a_frame_wr), 64'd32);
    chk("t4_done_pulses", 64'(a_done_cnt - base), 64'd1);
    chk("t4_exp_left", 64'(a_exp.size()), 64'd0);

    // Reset mid-frame
    push_frame(1'b0, 2, 4, 1, 31);
    a_frame_wr = 0; base = a_done_cnt;
    pulse_start(1'b0);
    wait_wr_a(5, 100);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_write_async_clear", 64'(a_if.mem_write), 64'd0);
    chk("t5_busy_clear", 64'(a_busy), 64'd0);
    chk("t5_done_clear", 64'(a_done), 64'd0);
    a_exp.delete();
    a_words.delete();
    a_frame_wr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    chk("t5_no_done", 64'(a_done_cnt - base), 64'd0);
    push_frame(1'b0, 2, 4, 1, 41);
    base = a_done_cnt;
    pulse_start(1'b0);
    wait_done(1'b0, 200);
    repeat (2) @(posedge clk);
    chk("t5_writes", 64'(a_frame_wr), 64'd32);
    chk("t5_exp_left", 64'(a_exp.size()), 64'd0);
    chk("t5_done_pulses", 64'(a_done_cnt - base), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
